// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the single-precision multiply sequencer.
package fp_mul_pkg;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int FRAC_W  = 23;
    localparam int EXP_W   = 8;
    localparam int MANT_W  = 24;

    typedef logic signed [EXP_W+1:0] exp_s_t;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_EXP  = 3'd1;
    localparam state_t S_MUL  = 3'd2;
    localparam state_t S_NORM = 3'd3;
    localparam state_t S_DONE = 3'd4;

endpackage

// File: rtl/fp_mul_if.sv
// Operand-in / result-out handshake bundle for fp_mul_ctrl.
interface fp_mul_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, overflow, underflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, overflow, underflow
    );

endinterface

// File: rtl/fp_mant_shift_add.sv
// Iterative shift-add mantissa multiplier: one multiplier bit per step.
module fp_mant_shift_add
    import fp_mul_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [MANT_W-1:0]     mcand_i,
    input  logic [MANT_W-1:0]     mplier_i,
    output logic [2*MANT_W-1:0]   prod_o
);

    logic [2*MANT_W-1:0] acc_q, acc_d;
    logic [MANT_W-1:0]   mcand_q, mcand_d;
    logic [MANT_W-1:0]   mplier_q, mplier_d;
    logic [MANT_W:0]     add;

    // Carry out of the upper-half add becomes the new MSB after the shift.
    assign add = {1'b0, acc_q[2*MANT_W-1:MANT_W]}
               + (mplier_q[0] ? {1'b0, mcand_q} : '0);

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = mcand_i;
            mplier_d = mplier_i;
        end else if (step_i) begin
            acc_d    = {add, acc_q[MANT_W-1:1]};
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign prod_o = acc_q;

endmodule

// File: rtl/fp_mul_ctrl.sv
// IEEE-754 single-precision multiply sequencer: EXP, 24-step MUL, NORM, DONE.
module fp_mul_ctrl
    import fp_mul_pkg::*;
#(
    parameter int BIAS   = fp_mul_pkg::BIAS,
    parameter int MANT_W = fp_mul_pkg::MANT_W
) (
    input  logic     clk,
    input  logic     rst_n,
    fp_mul_if.slave  bus
);

    localparam exp_s_t     BIAS_S    = exp_s_t'(BIAS);
    localparam exp_s_t     EXP_MAX_S = exp_s_t'(EXP_MAX);
    localparam logic [4:0] CNT_LAST  = 5'(MANT_W - 1);

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             zero_q, zero_d;
    logic [EXP_W-1:0] ea_q, ea_d;
    logic [EXP_W-1:0] eb_q, eb_d;
    exp_s_t           exp_q, exp_d;
    logic [31:0]      res_q, res_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             ovalid_q, ovalid_d;

    logic                 load, step;
    logic                 a_zero, b_zero;
    logic [23:0]          ma, mb;
    logic [47:0]          prod;
    exp_s_t               exp_n;
    logic [FRAC_W-1:0]    frac_n;
    logic [22:0]          prod_unused;

    assign a_zero = (bus.a[30:23] == '0);
    assign b_zero = (bus.b[30:23] == '0);
    assign ma     = a_zero ? '0 : {1'b1, bus.a[22:0]};
    assign mb     = b_zero ? '0 : {1'b1, bus.b[22:0]};

    fp_mant_shift_add u_mant (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .step_i   (step),
        .mcand_i  (ma),
        .mplier_i (mb),
        .prod_o   (prod)
    );

    // Product lies in [1,4): bit 47 set means one extra exponent step.
    assign exp_n       = prod[47] ? exp_q + exp_s_t'(1) : exp_q;
    assign frac_n      = prod[47] ? prod[46:24] : prod[45:23];
    assign prod_unused = prod[22:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        zero_d   = zero_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        exp_d    = exp_q;
        res_d    = res_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        ovalid_d = ovalid_q;
        load     = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    sign_d  = bus.a[31] ^ bus.b[31];
                    zero_d  = a_zero | b_zero;
                    ea_d    = bus.a[30:23];
                    eb_d    = bus.b[30:23];
                    cnt_d   = '0;
                    state_d = S_EXP;
                end
            end
            S_EXP: begin
                exp_d   = exp_s_t'({2'b00, ea_q})
                        + exp_s_t'({2'b00, eb_q}) - BIAS_S;
                state_d = S_MUL;
            end
            S_MUL: begin
                step  = 1'b1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                ovf_d = 1'b0;
                udf_d = 1'b0;
                if (zero_q) begin
                    res_d = {sign_q, 31'b0};
                end else if (exp_n >= EXP_MAX_S) begin
                    res_d = {sign_q, 8'hFF, 23'b0};
                    ovf_d = 1'b1;
                end else if (exp_n[9] || exp_n == '0) begin
                    res_d = {sign_q, 31'b0};
                    udf_d = 1'b1;
                end else begin
                    res_d = {sign_q, exp_n[7:0], frac_n};
                end
                ovalid_d = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    ovalid_d = 1'b0;
                    res_d    = '0;
                    ovf_d    = 1'b0;
                    udf_d    = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            ea_q     <= '0;
            eb_q     <= '0;
            exp_q    <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            zero_q   <= zero_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            exp_q    <= exp_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = ovalid_q;
    assign bus.result    = res_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;

endmodule

// File: tb/tb_fp_mul_ctrl.sv
// Directed-vector bench for fp_mul_ctrl.
module tb_fp_mul_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fp_mul_if bus ();

    fp_mul_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib);
        bus.a        = ia;
        bus.b        = ib;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] ia,
                       input logic [31:0] ib, input logic [31:0] er,
                       input logic eo, input logic eu);
        int lat;
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        issue(ia, ib);
        wait_out(lat);
        chk({tag, "_lat"}, 32'(lat), 32'd26);
        chk({tag, "_res"}, bus.result, er);
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'(eo));
        chk({tag, "_udf"}, 32'(bus.underflow), 32'(eu));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_vclr"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(bus.in_ready), 32'd1);
        chk("rst_vld", 32'(bus.out_valid), 32'd0);
        chk("rst_res", bus.result, 32'd0);
        chk("rst_flg", {30'd0, bus.overflow, bus.underflow}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run("m15x2",  32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
        run("m15x15", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0);
        run("zero",   32'h00000000, 32'hC0000000, 32'h80000000, 1'b0, 1'b0);
        run("ovf",    32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0);
        run("udf",    32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1);
        run("neg",    32'hC0000000, 32'h3FC00000, 32'hC0400000, 1'b0, 1'b0);

        // Backpressure: result held, busy pulse dropped.
        issue(32'h3FC00000, 32'h3FC00000);
        wait_out(lat);
        chk("bp_lat", 32'(lat), 32'd26);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i == 2);
            bus.a        = 32'h40000000;
            bus.b        = 32'h40000000;
            @(posedge clk);
            #1;
            chk($sformatf("bp_res%0d", i), bus.result, 32'h40100000);
            chk($sformatf("bp_vld%0d", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp_rdy%0d", i), 32'(bus.in_ready), 32'd0);
            chk($sformatf("bp_flg%0d", i),
                {30'd0, bus.overflow, bus.underflow}, 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("bp_rel_rdy", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_noq_rdy", 32'(bus.in_ready), 32'd1);
        chk("bp_noq_vld", 32'(bus.out_valid), 32'd0);

        // Asynchronous abort in the middle of MUL.
        issue(32'h3FC00000, 32'h40000000);
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rdy", 32'(bus.in_ready), 32'd1);
        chk("ar_vld", 32'(bus.out_valid), 32'd0);
        chk("ar_res", bus.result, 32'd0);
        chk("ar_flg", {30'd0, bus.overflow, bus.underflow}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run("post_rst", 32'h40000000, 32'h40000000, 32'h40800000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
